// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-path definitions: default PC width, reset PC and fetch FSM encodings.
// The decode stage imports the same package, so it sees identical state codes.
package pc_fetch_stage_pkg;

  localparam int          PC_W_DEF     = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage.sv
// PC register, deferred-branch holding register and IF/ID latch for the 16-bit MIPS fetch path.
// The PC incrementer is external: pc goes out, and pc+inc comes back on inc_r.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter bit              ALIGN_LSB = 1'b1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            stall,
  input  logic            flush,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] inc_r,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic [PC_W-1:0] ifid_pc,
  output logic [PC_W-1:0] ifid_pc_next,
  output logic            ifid_valid
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0] ifid_pc_next_q, ifid_pc_next_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [PC_W-1:0] br_tgt_m;

  assign br_tgt_m = ALIGN_LSB ? {br_target[PC_W-1:1], 1'b0} : br_target;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    ifid_valid_d   = ifid_valid_q;
    pend_d         = pend_q;
    pend_tgt_d     = pend_tgt_q;

    unique case (state_q)
      ST_BOOT: begin
        // First fetch of RESET_PC starts on this edge; nothing is in decode yet.
        state_d = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (stall) begin
          state_d = ST_STALL;
          if (br_taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = br_tgt_m;
          end
          // Flush must reach IF/ID even while the front end is frozen.
          if (flush) ifid_valid_d = 1'b0;
        end else begin
          state_d = ST_RUN;
          if (br_taken)    pc_d = br_tgt_m;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = inc_r;
          pend_d         = 1'b0;
          ifid_pc_d      = pc_q;
          ifid_pc_next_d = inc_r;
          // The instruction at pc is wrong-path whenever this edge redirects.
          ifid_valid_d   = ~(flush | br_taken | pend_q);
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: state is only ever updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
      ifid_valid_q   <= 1'b0;
      pend_q         <= 1'b0;
      pend_tgt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
      ifid_valid_q   <= ifid_valid_d;
      pend_q         <= pend_d;
      pend_tgt_q     <= pend_tgt_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = (state_q != ST_BOOT);
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pc_next = ifid_pc_next_q;
  assign ifid_valid   = ifid_valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a +2 incrementer wired from pc back to inc_r.
// Each table row is one clock edge: inputs driven before it, outputs compared just after it.
module tb_pc_fetch_stage;

  logic        clk;
  logic        clr;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] inc_r;
  logic [15:0] pc;
  logic        fetch_valid;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  pc_fetch_stage dut (
    .clk          (clk),
    .clr          (clr),
    .stall        (stall),
    .flush        (flush),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .inc_r        (inc_r),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid)
  );

  assign inc_r = pc + 16'd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic [15:0] e_ipc;
    logic [15:0] e_inx;
    logic        e_v;
    logic        e_fv;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [15:0] e_pc, input logic [15:0] e_ipc,
                           input logic [15:0] e_inx, input logic e_v, input logic e_fv);
    check("pc", idx, pc, e_pc);
    check("ifid_pc", idx, ifid_pc, e_ipc);
    check("ifid_pc_next", idx, ifid_pc_next, e_inx);
    check("ifid_valid", idx, {15'd0, ifid_valid}, {15'd0, e_v});
    check("fetch_valid", idx, {15'd0, fetch_valid}, {15'd0, e_fv});
  endtask

  task automatic add(input logic s, input logic f, input logic b, input logic [15:0] t,
                     input logic [15:0] p, input logic [15:0] ip, input logic [15:0] nx,
                     input logic v, input logic fv);
    vq.push_back('{s, f, b, t, p, ip, nx, v, fv});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  stall flush br  target    pc        ifid_pc   ifid_nx   v  fv
    add(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1); // BOOT edge
    add(0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 1);
    add(1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 1); // stall x3
    add(1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 1);
    add(1, 0, 0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h0008, 16'h0006, 16'h0008, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h000A, 16'h0008, 16'h000A, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h000C, 16'h000A, 16'h000C, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h000E, 16'h000C, 16'h000E, 1, 1);
    add(0, 0, 0, 16'h0000, 16'h0010, 16'h000E, 16'h0010, 1, 1);
    add(0, 0, 1, 16'h0041, 16'h0040, 16'h0010, 16'h0012, 0, 1); // taken branch, LSB masked
    add(0, 0, 0, 16'h0000, 16'h0042, 16'h0040, 16'h0042, 1, 1);
    add(0, 1, 0, 16'h0000, 16'h0044, 16'h0042, 16'h0044, 0, 1); // unstalled flush
    add(0, 0, 0, 16'h0000, 16'h0046, 16'h0044, 16'h0046, 1, 1);
    add(1, 0, 1, 16'h0100, 16'h0046, 16'h0044, 16'h0046, 1, 1); // deferred branch
    add(1, 0, 1, 16'h0200, 16'h0046, 16'h0044, 16'h0046, 1, 1); // latest target wins
    add(1, 1, 0, 16'h0000, 16'h0046, 16'h0044, 16'h0046, 0, 1); // flush beats stall
    add(0, 0, 0, 16'h0000, 16'h0200, 16'h0046, 16'h0048, 0, 1); // pend consumed
    add(0, 0, 0, 16'h0000, 16'h0202, 16'h0200, 16'h0202, 1, 1);
    add(1, 0, 1, 16'h0300, 16'h0202, 16'h0200, 16'h0202, 1, 1); // pend set
    add(0, 0, 1, 16'h0501, 16'h0500, 16'h0202, 16'h0204, 0, 1); // br_taken beats pend
    add(0, 0, 0, 16'h0000, 16'h0502, 16'h0500, 16'h0502, 1, 1); // pend was cleared
    add(0, 0, 1, 16'hFFFF, 16'hFFFE, 16'h0502, 16'h0504, 0, 1); // jump near top
    add(0, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 1, 1); // wrap
    add(0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 1, 1);
    add(1, 0, 1, 16'h0800, 16'h0002, 16'h0000, 16'h0002, 1, 1); // pend armed before reset

    clr = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    #3;
    check_all(100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #9; // t=12
    clr = 1'b1;

    foreach (vq[i]) begin
      stall     = vq[i].stall;
      flush     = vq[i].flush;
      br_taken  = vq[i].br;
      br_target = vq[i].tgt;
      @(posedge clk);
      #1;
      check_all(i, vq[i].e_pc, vq[i].e_ipc, vq[i].e_inx, vq[i].e_v, vq[i].e_fv);
      @(negedge clk);
    end

    // Async reset mid-stall with a redirect pending: outputs must clear without a clock edge.
    clr = 1'b0;
    #1;
    check_all(200, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_all(201, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_all(202, 16'h0002, 16'h0000, 16'h0002, 1'b1, 1'b1); // pending 0800 was lost

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
